// File: rtl/pool_ctrl.sv
// pool_ctrl: sequences feature-buffer reads for non-overlapping KxK pooling.
// Windows are scanned in raster order and pixels within a window row-major.
// Each read produces an element index (count) one cycle later and, on the
// last element of a window, a committed result (out_valid/out_addr) one
// cycle after that.
// Handshake: rd_en is a one-cycle read strobe with no back-pressure. stall
// only holds off new reads; data already issued always moves through the
// count and out_valid stages with fixed latency.
module pool_ctrl #(
  parameter int KERNAL_SIZE = 2,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 stall,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 rd_en,
  output logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic [KERNAL_SIZE*KERNAL_SIZE-1:0]   count,
  output logic                                 out_valid,
  output logic [ADDR_WIDTH-1:0]                out_addr,
  output logic [1:0]                           dbg_state
);

  localparam int KK = KERNAL_SIZE * KERNAL_SIZE;
  localparam int OW = IMG_W / KERNAL_SIZE;
  localparam int OH = IMG_H / KERNAL_SIZE;

  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] K_A    = ADDR_WIDTH'(KERNAL_SIZE);
  localparam logic [ADDR_WIDTH-1:0] W_A    = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] OW_A   = ADDR_WIDTH'(OW);
  localparam logic [ADDR_WIDTH-1:0] KM1_A  = ADDR_WIDTH'(KERNAL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] OWM1_A = ADDR_WIDTH'(OW - 1);
  localparam logic [ADDR_WIDTH-1:0] OHM1_A = ADDR_WIDTH'(OH - 1);
  localparam logic [KK-1:0]         CNT_ONE  = KK'(1);
  localparam logic [KK-1:0]         CNT_FULL = KK'(KK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q;

  // Scan counters point at the next pixel to read.
  logic [ADDR_WIDTH-1:0] wx_q, wy_q, ox_q, oy_q;
  logic [ADDR_WIDTH-1:0] wx_d, wy_d, ox_d, oy_d;

  // Read stage (visible on rd_en/rd_addr) plus side-band carried along.
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [KK-1:0]         rd_elem_q;
  logic [ADDR_WIDTH-1:0] rd_win_q;
  logic                  rd_last_q;

  // Count stage.
  logic [KK-1:0]         count_q;
  logic [ADDR_WIDTH-1:0] cnt_win_q;
  logic                  cnt_last_q;

  // Commit stage.
  logic                  out_valid_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic                  done_q;

  // Issue decision and the address/index of the pixel the counters point at.
  logic                  issue;
  logic                  last_elem;
  logic                  last_win;
  logic                  final_rd;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [ADDR_WIDTH-1:0] win_c;
  logic [KK-1:0]         elem_c;

  // Decode the current scan position and decide whether a read goes out.
  always_comb begin
    issue     = ((state_q == IDLE) && start) || ((state_q == RUN) && !stall);
    last_elem = (wx_q == KM1_A) && (wy_q == KM1_A);
    last_win  = (ox_q == OWM1_A) && (oy_q == OHM1_A);
    final_rd  = last_elem && last_win;
    addr_c    = (oy_q * K_A + wy_q) * W_A + ox_q * K_A + wx_q;
    win_c     = oy_q * OW_A + ox_q;
    elem_c    = KK'(wy_q * K_A + wx_q) + CNT_ONE;
  end

  // Advance the scan counters on each issued read, wrapping at their limits.
  always_comb begin
    wx_d = wx_q;
    wy_d = wy_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (issue) begin
      if (wx_q == KM1_A) begin
        wx_d = '0;
        if (wy_q == KM1_A) begin
          wy_d = '0;
          if (ox_q == OWM1_A) begin
            ox_d = '0;
            oy_d = (oy_q == OHM1_A) ? '0 : oy_q + ONE_A;
          end else begin
            ox_d = ox_q + ONE_A;
          end
        end else begin
          wy_d = wy_q + ONE_A;
        end
      end else begin
        wx_d = wx_q + ONE_A;
      end
    end
  end

  // Control FSM, scan counters and the read -> count -> commit pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wx_q        <= '0;
      wy_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      rd_win_q    <= '0;
      rd_last_q   <= 1'b0;
      count_q     <= '0;
      cnt_win_q   <= '0;
      cnt_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      wx_q <= wx_d;
      wy_q <= wy_d;
      ox_q <= ox_d;
      oy_q <= oy_d;

      count_q    <= rd_en_q ? rd_elem_q : '0;
      cnt_win_q  <= rd_win_q;
      cnt_last_q <= rd_en_q && rd_last_q;

      out_valid_q <= (count_q == CNT_FULL);
      if (count_q == CNT_FULL) out_addr_q <= cnt_win_q;
      done_q <= cnt_last_q;

      rd_en_q <= issue;
      if (issue) begin
        rd_addr_q <= addr_c;
        rd_elem_q <= elem_c;
        rd_win_q  <= win_c;
        rd_last_q <= final_rd;
      end

      case (state_q)
        IDLE:    if (start) state_q <= RUN;
        RUN:     if (issue && final_rd) state_q <= DRAIN;
        DRAIN:   if (done_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pool_ctrl.sv
// Bench for pool_ctrl on a 4x4 map with 2x2 windows.
module tb_pool_ctrl;

  localparam int K  = 2;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int KK = K * K;
  localparam int OW = W / K;
  localparam int N  = W * H;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic          busy, done, rd_en, out_valid;
  logic [AW-1:0] rd_addr, out_addr;
  logic [KK-1:0] count;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  pool_ctrl #(.KERNAL_SIZE(K), .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .count(count), .out_valid(out_valid), .out_addr(out_addr),
    .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A pass is the sequence of linear read numbers 0..N-1. Read n lands on
  // rd_en one cycle after it is decided, its element index two cycles after,
  // and its window commit three cycles after.
  function automatic logic [AW-1:0] addr_of(input int n);
    int w, e;
    w = n / KK;
    e = n % KK;
    return AW'(((w / OW) * K + e / K) * W + (w % OW) * K + e % K);
  endfunction

  bit            m_active = 0;
  int            m_next   = 0;
  bit            s1v = 0, s2v = 0, s3v = 0;
  int            s1n = 0, s2n = 0, s3n = 0;
  logic [AW-1:0] m_rd_addr  = '0;
  logic [AW-1:0] m_out_addr = '0;

  initial forever begin
    bit done_now;
    @(posedge clk);
    if (reset) begin
      m_active = 0; m_next = 0;
      s1v = 0; s2v = 0; s3v = 0;
      m_rd_addr = '0; m_out_addr = '0;
    end else begin
      done_now = s3v && (s3n == N - 1);
      s3v = s2v; s3n = s2n;
      s2v = s1v; s2n = s1n;
      s1v = 0;
      if (!m_active) begin
        if (start) begin
          s1v = 1; s1n = 0; m_next = 1; m_active = 1;
        end
      end else if (done_now) begin
        m_active = 0;
      end else if (m_next < N && !stall) begin
        s1v = 1; s1n = m_next; m_next++;
      end
      if (s1v) m_rd_addr = addr_of(s1n);
      if (s3v && (s3n % KK) == KK - 1) m_out_addr = AW'(s3n / KK);
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("m_busy",      busy,      m_active);
      chk("m_rd_en",     rd_en,     s1v);
      chk("m_rd_addr",   rd_addr,   m_rd_addr);
      chk("m_count",     count,     s2v ? (s2n % KK) + 1 : 0);
      chk("m_out_valid", out_valid, s3v && (s3n % KK) == KK - 1);
      chk("m_out_addr",  out_addr,  m_out_addr);
      chk("m_done",      done,      s3v && (s3n == N - 1));
    end
  end

  // ---------------- traces for literal checks ----------------
  logic          t_rd_en[64], t_ov[64], t_done[64], t_busy[64];
  logic [AW-1:0] t_rd_addr[64], t_oa[64];
  logic [KK-1:0] t_count[64];

  // Called just after a rising edge; cycle 0 is the current cycle.
  task automatic run_trace(input int len, input int stall_lo, input int stall_hi,
                           input int reset_at, input int start_until);
    for (int c = 0; c < len; c++) begin
      start = (c <= start_until);
      stall = (c >= stall_lo) && (c <= stall_hi);
      reset = (c == reset_at);
      @(negedge clk);
      t_rd_en[c] = rd_en;   t_rd_addr[c] = rd_addr; t_count[c] = count;
      t_ov[c]    = out_valid; t_oa[c] = out_addr;  t_done[c]  = done;
      t_busy[c]  = busy;
      @(posedge clk); #1;
    end
    start = 0; stall = 0; reset = 0;
  endtask

  task automatic check_plain(input string tag);
    logic [AW-1:0] exp_addr [16] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd2, 4'd3, 4'd6, 4'd7,
                                     4'd8, 4'd9, 4'd12, 4'd13, 4'd10, 4'd11, 4'd14, 4'd15};
    bit ov_exp;
    for (int c = 0; c <= 20; c++) begin
      chk({tag, "_rd_en"}, t_rd_en[c], (c >= 1 && c <= 16));
      if (c >= 1 && c <= 16) chk({tag, "_rd_addr"}, t_rd_addr[c], exp_addr[c-1]);
      chk({tag, "_count"}, t_count[c], (c >= 2 && c <= 17) ? ((c - 2) % 4) + 1 : 0);
      ov_exp = (c == 6) || (c == 10) || (c == 14) || (c == 18);
      chk({tag, "_out_valid"}, t_ov[c], ov_exp);
      if (ov_exp) chk({tag, "_out_addr"}, t_oa[c], (c - 6) / 4);
      chk({tag, "_done"}, t_done[c], (c == 18));
      chk({tag, "_busy"}, t_busy[c], (c >= 1 && c <= 18));
    end
  endtask

  task automatic wait_idle(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1;
      @(posedge clk); #1;
    end
    chk({tag, "_idle_timeout"}, seen, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ndone;
    reset = 1; start = 0; stall = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    cmp_en = 1'b1;

    // reset values
    @(negedge clk);
    chk("rst_busy", busy, 0);  chk("rst_rd_en", rd_en, 0);   chk("rst_rd_addr", rd_addr, 0);
    chk("rst_count", count, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0); chk("rst_done", done, 0);
    @(posedge clk); #1;

    // pinned model values
    chk("model_addr_2", addr_of(2), 4);
    chk("model_addr_12", addr_of(12), 10);
    chk("model_addr_15", addr_of(15), 15);

    // uninterrupted pass
    run_trace(21, -1, -1, -1, 0);
    check_plain("plain");

    // stall during the first window
    run_trace(22, 2, 3, -1, 0);
    chk("stall_rd_en_3", t_rd_en[3], 0);
    chk("stall_rd_en_4", t_rd_en[4], 0);
    chk("stall_rd_en_5", t_rd_en[5], 1);
    chk("stall_rd_addr_5", t_rd_addr[5], 4);
    chk("stall_count_4", t_count[4], 0);
    chk("stall_count_5", t_count[5], 0);
    chk("stall_ov_6", t_ov[6], 0);
    chk("stall_ov_7", t_ov[7], 0);
    chk("stall_ov_8", t_ov[8], 1);
    chk("stall_done_18", t_done[18], 0);
    chk("stall_done_20", t_done[20], 1);
    chk("stall_busy_21", t_busy[21], 0);

    // reset in the middle of a pass
    run_trace(26, -1, -1, 9, 0);
    for (int c = 10; c < 26; c++) begin
      chk("abort_busy", t_busy[c], 0);   chk("abort_rd_en", t_rd_en[c], 0);
      chk("abort_rd_addr", t_rd_addr[c], 0); chk("abort_count", t_count[c], 0);
      chk("abort_ov", t_ov[c], 0);       chk("abort_oa", t_oa[c], 0);
      chk("abort_done", t_done[c], 0);
    end
    run_trace(21, -1, -1, -1, 0);
    check_plain("rerun");

    // start held high across a whole pass
    run_trace(22, -1, -1, -1, 19);
    ndone = 0;
    for (int c = 0; c < 20; c++) ndone += int'(t_done[c]);
    chk("hold_single_done", ndone, 1);
    chk("hold_done_18", t_done[18], 1);
    chk("hold_busy_19", t_busy[19], 0);
    chk("hold_restart_rd_en", t_rd_en[20], 1);
    chk("hold_restart_addr", t_rd_addr[20], 0);
    wait_idle("hold");

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 99) < 30);
      @(posedge clk); #1;
    end
    reset = 0; start = 0; stall = 0;
    wait_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
